// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding
// and default geometry.
package regfile_mp_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_REGBITS = 5;

  // CLEAR zeroes the array one entry per cycle; RUN is normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Read-data selector for one read port of regfile_mp.
// Ports:
//   run_i    - array is readable (RUN state, reset low); otherwise reads zero
//   ra_i     - read address; address 0 always reads zero
//   ram_rd_i - raw array data at ra_i
//   we*/wa*/wd* - current-cycle write ports, forwarded when BYPASS != 0
//   rd_o     - combinational read data
module regfile_bypass_mux
  import regfile_mp_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned REGBITS = DEF_REGBITS,
  parameter int unsigned BYPASS  = 1
) (
  input  logic               run_i,
  input  logic [REGBITS-1:0] ra_i,
  input  logic [WIDTH-1:0]   ram_rd_i,
  input  logic               we0_i,
  input  logic [REGBITS-1:0] wa0_i,
  input  logic [WIDTH-1:0]   wd0_i,
  input  logic               we1_i,
  input  logic [REGBITS-1:0] wa1_i,
  input  logic [WIDTH-1:0]   wd1_i,
  output logic [WIDTH-1:0]   rd_o
);

  // Port 1 has priority over port 0, matching the array's write precedence.
  always_comb begin
    rd_o = '0;
    if (run_i && (ra_i != '0)) begin
      rd_o = ram_rd_i;
      if (BYPASS != 0) begin
        if (we1_i && (wa1_i == ra_i)) begin
          rd_o = wd1_i;
        end else if (we0_i && (wa0_i == ra_i)) begin
          rd_o = wd0_i;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write / two-read register file that zeroes itself after reset by
// sweeping the array, one entry per cycle, before accepting traffic.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   we0/wa0/wd0  - write port 0
//   we1/wa1/wd1  - write port 1 (wins on address collision)
//   ra1/ra2      - read addresses
//   rd1/rd2      - combinational read data (zero during CLEAR/reset)
//   busy         - high while the clear sweep runs
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned REGBITS = DEF_REGBITS,
  parameter int unsigned BYPASS  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we0,
  input  logic [REGBITS-1:0] wa0,
  input  logic [WIDTH-1:0]   wd0,
  input  logic               we1,
  input  logic [REGBITS-1:0] wa1,
  input  logic [WIDTH-1:0]   wd1,
  input  logic [REGBITS-1:0] ra1,
  input  logic [REGBITS-1:0] ra2,
  output logic [WIDTH-1:0]   rd1,
  output logic [WIDTH-1:0]   rd2,
  output logic               busy
);

  localparam int unsigned DEPTH = 1 << REGBITS;

  state_e             state_q, state_d;
  logic [REGBITS-1:0] cnt_q, cnt_d;
  logic               clr_we_c;
  logic               run_c;
  logic               wr0_c, wr1_c;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  // State register; cnt starts at 1 because entry 0 is never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= REGBITS'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: sweep to the top entry, then leave CLEAR without wrapping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we_c = !reset;
        if (cnt_q == '1) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + REGBITS'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // A write coinciding with reset is dropped, as are writes to entry 0.
  assign run_c = (state_q == ST_RUN) && !reset;
  assign wr0_c = run_c && we0 && (wa0 != '0);
  assign wr1_c = run_c && we1 && (wa1 != '0);
  assign busy  = (state_q == ST_CLEAR);

  // Storage: port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_we_c) mem_q[cnt_q] <= '0;
    if (wr0_c)    mem_q[wa0]   <= wd0;
    if (wr1_c)    mem_q[wa1]   <= wd1;
  end

  regfile_bypass_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS), .BYPASS(BYPASS)) u_mux1 (
    .run_i(run_c), .ra_i(ra1), .ram_rd_i(mem_q[ra1]),
    .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0),
    .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
    .rd_o(rd1)
  );

  regfile_bypass_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS), .BYPASS(BYPASS)) u_mux2 (
    .run_i(run_c), .ra_i(ra2), .ram_rd_i(mem_q[ra2]),
    .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0),
    .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
    .rd_o(rd2)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one instance with forwarding, one without, both
// driven by the same stimulus and checked against an array-based model.
module tb_regfile_mp;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, ra1 = '0, ra2 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy_b, busy_n;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_mem [DEPTH];
  int          m_clear_left = DEPTH - 1;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .REGBITS(5), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b), .busy(busy_b)
  );

  regfile_mp #(.WIDTH(32), .REGBITS(5), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n), .busy(busy_n)
  );

  // Reference model: a countdown of remaining entries to zero, then plain
  // array writes with port 1 applied after port 0.
  always @(posedge clk) begin
    if (reset) begin
      m_clear_left = DEPTH - 1;
    end else if (m_clear_left != 0) begin
      m_mem[DEPTH - m_clear_left] = '0;
      m_clear_left = m_clear_left - 1;
    end else begin
      if (we0 && wa0 != 0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 0) m_mem[wa1] = wd1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (reset || m_clear_left != 0 || ra == 0) return '0;
    if (byp && we1 && wa1 == ra) return wd1;
    if (byp && we0 && wa0 == ra) return wd0;
    return m_mem[ra];
  endfunction

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  // Drive one cycle's inputs just after the falling edge.
  task automatic set_in(input logic r, input logic e0, input logic [4:0] a0,
                        input logic [31:0] d0, input logic e1, input logic [4:0] a1,
                        input logic [31:0] d1, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    reset = r; we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
    ra1 = r1; ra2 = r2;
    #1;
  endtask

  task automatic test_reset();
    int n;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd4, 5'd7);
      if (i > 0) begin
        n_vec++;
        if (busy_b !== 1'b1 || busy_n !== 1'b1) begin
          n_err++; $display("FAIL reset_busy: got %b/%b expected 1", busy_b, busy_n);
        end
        n_vec++;
        if (rd1_b !== 32'd0 || rd2_n !== 32'd0) begin
          n_err++; $display("FAIL reset_rd: got %h/%h expected 0", rd1_b, rd2_n);
        end
      end
    end
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    n = 0;
    while (busy_b === 1'b1 && n < 100) begin
      n_vec++;
      if (busy_n !== (m_clear_left != 0)) begin
        n_err++; $display("FAIL clear_busy_n: got %b expected %b", busy_n, m_clear_left != 0);
      end
      n++;
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    end
    n_vec++;
    if (n != 31) begin
      n_err++; $display("FAIL busy_len: got %0d expected 31", n);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'(a), 5'(DEPTH - 1 - a));
      n_vec++;
      if (rd1_b !== 32'd0 || rd2_b !== 32'd0 || rd1_n !== 32'd0 || rd2_n !== 32'd0 ||
          busy_b !== 1'b0 || busy_n !== 1'b0) begin
        n_err++; $display("FAIL post_clear_read a=%0d: got %h %h %h %h busy %b%b expected 0",
                          a, rd1_b, rd2_b, rd1_n, rd2_n, busy_b, busy_n);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old;
    set_in(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    set_in(1'b0, 1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    old = m_mem[5];
    n_vec++;
    if (rd1_b !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL bypass_same: got %h expected a5a5a5a5", rd1_b);
    end
    n_vec++;
    if (rd1_n !== old || old !== 32'h1234_5678) begin
      n_err++; $display("FAIL nobypass_same: got %h expected %h", rd1_n, 32'h1234_5678);
    end
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    n_vec++;
    if (rd1_b !== 32'hA5A5_A5A5 || rd1_n !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL bypass_next: got %h/%h expected a5a5a5a5", rd1_b, rd1_n);
    end
  endtask

  task automatic test_dual_same();
    set_in(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd0, 5'd7);
    n_vec++;
    if (rd2_b !== 32'h22) begin
      n_err++; $display("FAIL dual_bypass: got %h expected 22", rd2_b);
    end
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    n_vec++;
    if (rd1_b !== 32'h22 || rd2_n !== 32'h22) begin
      n_err++; $display("FAIL dual_store: got %h/%h expected 22", rd1_b, rd2_n);
    end
    set_in(1'b0, 1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
    n_vec++;
    if (rd1_n !== 32'hAAAA || rd2_n !== 32'hBBBB) begin
      n_err++; $display("FAIL dual_distinct: got %h/%h expected aaaa/bbbb", rd1_n, rd2_n);
    end
  endtask

  task automatic test_zero_reg();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    n_vec++;
    if (rd1_b !== 32'd0 || rd1_n !== 32'd0) begin
      n_err++; $display("FAIL zero_same: got %h/%h expected 0", rd1_b, rd1_n);
    end
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    n_vec++;
    if (rd1_b !== 32'd0 || rd1_n !== 32'd0) begin
      n_err++; $display("FAIL zero_next: got %h/%h expected 0", rd1_b, rd1_n);
    end
  endtask

  task automatic test_random();
    logic [4:0] a0, a1, r1, r2;
    logic [31:0] e1b, e2b, e1n, e2n;
    for (int i = 0; i < 300; i++) begin
      a0 = rand_addr();
      a1 = rand_addr();
      r1 = ($urandom_range(0, 2) == 0) ? a0 : rand_addr();
      r2 = ($urandom_range(0, 2) == 0) ? a1 : rand_addr();
      set_in(1'b0, 1'($urandom_range(0, 1)), a0, $urandom, 1'($urandom_range(0, 1)), a1,
             $urandom, r1, r2);
      e1b = exp_rd(r1, 1'b1); e2b = exp_rd(r2, 1'b1);
      e1n = exp_rd(r1, 1'b0); e2n = exp_rd(r2, 1'b0);
      n_vec++;
      if (rd1_b !== e1b || rd2_b !== e2b) begin
        n_err++; $display("FAIL rand_bypass i=%0d: got %h %h expected %h %h", i, rd1_b, rd2_b, e1b, e2b);
      end
      n_vec++;
      if (rd1_n !== e1n || rd2_n !== e2n) begin
        n_err++; $display("FAIL rand_nobypass i=%0d: got %h %h expected %h %h", i, rd1_n, rd2_n, e1n, e2n);
      end
    end
  endtask

  task automatic test_clear_write();
    int n;
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    set_in(1'b0, 1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    n_vec++;
    if (rd1_b !== 32'd0 || rd2_n !== 32'd0) begin
      n_err++; $display("FAIL clear_read: got %h/%h expected 0", rd1_b, rd2_n);
    end
    n = 0;
    while (busy_b === 1'b1 && n < 100) begin
      n++;
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    end
    n_vec++;
    if (n >= 100 || rd1_b !== 32'd0 || rd2_n !== 32'd0) begin
      n_err++; $display("FAIL clear_write_ignored: got %h/%h after %0d cycles expected 0", rd1_b, rd2_n, n);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    set_in(1'b0, 1'b1, 5'd9, 32'h33, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    n_vec++;
    if (rd1_b !== 32'h33 || rd2_n !== 32'h33) begin
      n_err++; $display("FAIL reg9_write: got %h/%h expected 33", rd1_b, rd2_n);
    end
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    for (int i = 0; i < 10; i++) set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    n = 0;
    while (busy_b === 1'b1 && n < 100) begin
      n++;
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    end
    n_vec++;
    if (n != 31 || busy_n !== 1'b0) begin
      n_err++; $display("FAIL restart_busy_len: got %0d busy_n %b expected 31 / 0", n, busy_n);
    end
    n_vec++;
    if (rd1_b !== 32'd0 || rd2_n !== 32'd0) begin
      n_err++; $display("FAIL reg9_cleared: got %h/%h expected 0", rd1_b, rd2_n);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    test_reset();
    test_bypass();
    test_dual_same();
    test_zero_reg();
    test_random();
    test_clear_write();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
